alu_addsub_pipe: RTL and testbench

ALU_ADDSUB_PIPE -- requirements
Module: alu_addsub_pipe

---
 rtl/alu_addsub_pipe_pkg.sv | 18 +
 rtl/alu_addsub_pipe_slice.sv | 29 ++
 rtl/alu_addsub_pipe.sv | 130 +++++++++++++
 tb/tb_alu_addsub_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_addsub_pipe_pkg.sv
// Shared definitions for the chunked add/subtract pipeline: op encodings,
// default geometry and the registered flag bundle.
package alu_addsub_pipe_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    localparam int ALU_WIDTH_DEF = 64;
    localparam int ALU_CHUNK_DEF = 16;

    typedef struct packed {
        logic of;
        logic cf;
        logic zf;
        logic sf;
    } alu_flags_t;

endpackage

// File: rtl/alu_addsub_pipe_slice.sv
// CHUNK-bit ripple-carry slice; also exposes the carry into its top bit so the
// final stage can form signed overflow.
module addsub_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = carry[CHUNK];
    assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/alu_addsub_pipe.sv
// Signed add/subtract resolved CHUNK bits per stage; the carry and the operand
// bits still to be consumed ride along with each transaction.
module alu_addsub_pipe
    import alu_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF,
    parameter int CHUNK = ALU_CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             of,
    output logic             cf,
    output logic             zf,
    output logic             sf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam int FW     = (STAGES > 1) ? STAGES - 1 : 1;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe advances unless the output holds an untaken result, so
    // in_ready is simply "not stalled" and bubbles move like real entries.
    logic advance;

    logic [FW-1:0][WIDTH-1:0]     a_q, b_q;
    logic [FW-1:0]                c_q, op_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic [STAGES-1:0]            v_q;
    alu_flags_t                   flags_q, flags_d;

    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in;
    logic [STAGES-1:0]            v_in, op_in, c_in, cout;
    logic [STAGES-1:0][CHUNK-1:0] sum;
    logic                         cmsb_last;

    assign out_valid = v_q[LAST];
    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance;

    assign s  = s_q[LAST];
    assign of = flags_q.of;
    assign cf = flags_q.cf;
    assign zf = flags_q.zf;
    assign sf = flags_q.sf;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic cmsb_k;

        if (k == 0) begin : g_head
            // Subtract is a + ~b + 1: invert b once here, seed carry-in with op.
            assign a_in[k]  = a;
            assign b_in[k]  = (op == ALU_OP_SUB) ? ~b : b;
            assign s_in[k]  = '0;
            assign v_in[k]  = in_valid;
            assign op_in[k] = op;
            assign c_in[k]  = (op == ALU_OP_SUB);
        end else begin : g_body
            logic unused_lo;
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign s_in[k]   = s_q[k-1];
            assign v_in[k]   = v_q[k-1];
            assign op_in[k]  = op_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign unused_lo = ^{a_in[k][k*CHUNK-1:0], b_in[k][k*CHUNK-1:0]};
        end

        addsub_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a_i   (a_in[k][k*CHUNK +: CHUNK]),
            .b_i   (b_in[k][k*CHUNK +: CHUNK]),
            .cin_i (c_in[k]),
            .sum_o (sum[k]),
            .cout_o(cout[k]),
            .cmsb_o(cmsb_k)
        );

        if (k == LAST) begin : g_tail
            assign cmsb_last = cmsb_k;
        end else begin : g_mid
            logic unused_cmsb;
            assign unused_cmsb = cmsb_k;
        end
    end

    always_comb begin
        s_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k]                   = s_in[k];
            s_d[k][k*CHUNK +: CHUNK] = sum[k];
        end
        flags_d.of = cmsb_last ^ cout[LAST];
        flags_d.cf = (op_in[LAST] == ALU_OP_SUB) ? ~cout[LAST] : cout[LAST];
        flags_d.zf = (s_d[LAST] == '0);
        flags_d.sf = s_d[LAST][WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            op_q    <= '0;
            flags_q <= '0;
        end else if (advance) begin
            v_q     <= v_in;
            s_q     <= s_d;
            flags_q <= flags_d;
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k]  <= a_in[k];
                b_q[k]  <= b_in[k];
                c_q[k]  <= cout[k];
                op_q[k] <= op_in[k];
            end
        end
    end

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Directed bench for alu_addsub_pipe at WIDTH=64, CHUNK=16 (four stages).
module tb_alu_addsub_pipe;
    import alu_addsub_pipe_pkg::*;

    localparam int W   = 64;
    localparam int EW  = W + 4;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         of, cf, zf, sf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic          chk_lat;
    logic          hold_v;
    logic [EW-1:0] hold_val;
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];

    alu_addsub_pipe #(
        .WIDTH(W),
        .CHUNK(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .of       (of),
        .cf       (cf),
        .zf       (zf),
        .sf       (sf)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [EW-1:0] mk(input logic [W-1:0] sv, input logic o, input logic c,
                                         input logic z, input logic n);
        return {sv, o, c, z, n};
    endfunction

    function automatic logic [EW-1:0] cur();
        return {s, of, cf, zf, sf};
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard side: a result leaves on the coming edge when valid && ready
    task automatic observe();
        if (out_valid && !out_ready) begin
            check("in_ready_stall", EW'(in_ready), EW'(1'b0));
            if (hold_v) check("hold_stable", cur(), hold_val);
            hold_v   = 1'b1;
            hold_val = cur();
        end else begin
            hold_v = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", EW'(out_valid), EW'(1'b0));
            end else begin
                int ac;
                check("result", cur(), exp_q.pop_front());
                ac = acc_q.pop_front();
                if (chk_lat) check("latency", EW'(cyc - ac), EW'(LAT));
            end
        end
    endtask

    // driver
    task automatic step(input logic v, input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [EW-1:0] ev, input logic rdy, output logic acc);
        @(negedge clk);
        in_valid  = v;
        op        = o;
        a         = av;
        b         = bv;
        out_ready = rdy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back(ev);
            acc_q.push_back(cyc);
        end
        observe();
    endtask

    task automatic send(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [EW-1:0] ev, input logic rdy);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            step(1'b1, o, av, bv, ev, rdy, acc);
            n++;
        end
        if (!acc) check("send_timeout", EW'(acc), EW'(1'b1));
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        repeat (n) step(1'b0, ALU_OP_ADD, '0, '0, '0, rdy, acc);
    endtask

    initial begin
        logic acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = ALU_OP_ADD;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        chk_lat   = 1'b0;
        hold_v    = 1'b0;
        hold_val  = '0;

        #2;
        check("rst_out_valid", EW'(out_valid), EW'(1'b0));
        check("rst_outputs", cur(), '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", EW'(in_ready), EW'(1'b1));

        // back-to-back directed vectors
        chk_lat = 1'b1;
        send(ALU_OP_SUB, 64'd5, 64'd3, mk(64'd2, 0, 0, 0, 0), 1'b1);
        send(ALU_OP_SUB, 64'd7, 64'd7, mk(64'd0, 0, 0, 1, 0), 1'b1);
        send(ALU_OP_SUB, 64'h8000000000000000, 64'd1, mk(64'h7FFFFFFFFFFFFFFF, 1, 0, 0, 0), 1'b1);
        send(ALU_OP_SUB, 64'd3, 64'd5, mk(64'hFFFFFFFFFFFFFFFE, 0, 1, 0, 1), 1'b1);
        send(ALU_OP_ADD, 64'h7FFFFFFFFFFFFFFF, 64'd1, mk(64'h8000000000000000, 1, 0, 0, 1), 1'b1);
        send(ALU_OP_ADD, 64'hFFFFFFFFFFFFFFFF, 64'd1, mk(64'd0, 0, 1, 1, 0), 1'b1);
        send(ALU_OP_ADD, 64'h000000000000FFFF, 64'd1, mk(64'h0000000000010000, 0, 0, 0, 0), 1'b1);
        send(ALU_OP_SUB, 64'd0, 64'd1, mk(64'hFFFFFFFFFFFFFFFF, 0, 1, 0, 1), 1'b1);
        idle(8, 1'b1);
        check("b2b_drain", EW'(exp_q.size()), EW'(0));

        // four in flight, then three stalled cycles with a fifth op waiting
        chk_lat = 1'b0;
        send(ALU_OP_ADD, 64'h1234, 64'h1, mk(64'h1235, 0, 0, 0, 0), 1'b0);
        send(ALU_OP_ADD, 64'h0001000000000000, 64'h0000FFFFFFFFFFFF, mk(64'h0001FFFFFFFFFFFF, 0, 0, 0, 0), 1'b0);
        send(ALU_OP_SUB, 64'h10, 64'h20, mk(64'hFFFFFFFFFFFFFFF0, 0, 1, 0, 1), 1'b0);
        send(ALU_OP_ADD, 64'h8000000000000000, 64'h8000000000000000, mk(64'd0, 1, 1, 1, 0), 1'b0);
        repeat (3) step(1'b1, ALU_OP_SUB, 64'd100, 64'd100, mk(64'd0, 0, 0, 1, 0), 1'b0, acc);
        send(ALU_OP_SUB, 64'd100, 64'd100, mk(64'd0, 0, 0, 1, 0), 1'b1);
        idle(10, 1'b1);
        check("stall_drain", EW'(exp_q.size()), EW'(0));

        // reset with three transactions in flight
        send(ALU_OP_ADD, 64'd1, 64'd1, mk(64'd2, 0, 0, 0, 0), 1'b0);
        send(ALU_OP_ADD, 64'd2, 64'd2, mk(64'd4, 0, 0, 0, 0), 1'b0);
        send(ALU_OP_SUB, 64'd9, 64'd4, mk(64'd5, 0, 0, 0, 0), 1'b0);
        idle(2, 1'b0);
        check("pre_rst_valid", EW'(out_valid), EW'(1'b1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", EW'(out_valid), EW'(1'b0));
        check("mid_rst_outputs", cur(), '0);
        exp_q.delete();
        acc_q.delete();
        hold_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", EW'(in_ready), EW'(1'b1));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, ALU_OP_ADD, '0, '0, '0, 1'b1, acc);
            check("post_rst_valid", EW'(out_valid), EW'(1'b0));
        end

        chk_lat = 1'b1;
        send(ALU_OP_ADD, 64'd1, 64'd2, mk(64'd3, 0, 0, 0, 0), 1'b1);
        send(ALU_OP_SUB, 64'h10000, 64'd1, mk(64'h000000000000FFFF, 0, 0, 0, 0), 1'b1);
        idle(8, 1'b1);
        check("final_drain", EW'(exp_q.size()), EW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
